// File: rtl/pc_trace_uart.sv
// Instruction-trace streamer: captures the selected core's retired PCs into a FIFO and sends
// each one as an 8N1 UART frame. Define PC_TRACE_DEDUP_EN to drop repeated (stalled) PCs.
module pc_trace_uart #(
    parameter int NUM_CORES  = 2,
    parameter int PC_W       = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 87
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic [3:0]                core_sel_i,
    input  logic [NUM_CORES*PC_W-1:0] buy_ps_i,
    input  logic [NUM_CORES-1:0]      buy_gecerli_i,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_count_o
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 4 + PC_W;
    localparam int NBYTES  = PC_W / 8;
    localparam int BW      = $clog2(NBYTES + 1);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int FRAME_W = 8 + PC_W;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic                 sel_valid;
    logic [PC_W-1:0]      sel_pc;
    logic                 capture, is_dup, push, drop, pop;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   head;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        byte_idx;
    logic [FRAME_W-1:0]   frame_sr;
    logic [7:0]           cur_byte;
    logic                 tx_q, tx_next;

    // Out-of-range selections never match any core, so they capture nothing.
    always_comb begin
        sel_valid = 1'b0;
        sel_pc    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (core_sel_i == 4'(k)) begin
                sel_valid = buy_gecerli_i[k];
                sel_pc    = buy_ps_i[k*PC_W +: PC_W];
            end
        end
    end

    assign capture = en_i & sel_valid;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = capture & ~is_dup & ~full;
    assign drop    = capture & ~is_dup & full;
    assign pop     = (state == IDLE) & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

`ifdef PC_TRACE_DEDUP_EN
    logic            last_valid;
    logic [PC_W-1:0] last_pc;
    logic [3:0]      prev_sel;

    assign is_dup = last_valid && (core_sel_i == prev_sel) && (sel_pc == last_pc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_valid <= 1'b0;
            last_pc    <= '0;
            prev_sel   <= '0;
        end else begin
            prev_sel <= core_sel_i;
            if (push) begin
                last_valid <= 1'b1;
                last_pc    <= sel_pc;
            end else if (!en_i || core_sel_i != prev_sel) begin
                last_valid <= 1'b0;
            end
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {core_sel_i, sel_pc};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (clr_i) begin
                overflow_o   <= 1'b0;
                drop_count_o <= '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
            end
        end
    end

    assign tick     = (div_cnt == DW'(CLK_DIV - 1));
    assign cur_byte = frame_sr[7:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            IDLE:  if (!empty) state_next = START;
            START: begin
                tx_next = 1'b0;
                if (tick) state_next = DATA;
            end
            DATA: begin
                tx_next = cur_byte[bit_idx];
                if (tick && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: if (tick) state_next = (byte_idx < BW'(NBYTES)) ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The line is driven from a register, so the start bit appears one cycle after START is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q     <= 1'b1;
            div_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame_sr <= '0;
        end else begin
            tx_q <= tx_next;
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;
            if (pop) begin
                frame_sr <= {head[PC_W-1:0], 4'hA, head[ENTRY_W-1 -: 4]};
                byte_idx <= '0;
                bit_idx  <= '0;
            end
            if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
            if (state == STOP && tick) begin
                frame_sr <= frame_sr >> 8;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_pc_trace_uart.sv
// Self-checking bench for pc_trace_uart: a UART receiver decodes tx and the bytes are compared
// against frames predicted from the capture rules. Honours PC_TRACE_DEDUP_EN when defined.
module tb_pc_trace_uart;

    localparam int NUM_CORES  = 2;
    localparam int PC_W       = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 4;
    localparam int NBYTES     = PC_W / 8;
    localparam int FRAME_CYC  = (1 + NBYTES) * 10 * CLK_DIV;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en = 1'b0;
    logic                      clr = 1'b0;
    logic [3:0]                core_sel = 4'd0;
    logic [NUM_CORES*PC_W-1:0] pcs = '0;
    logic [NUM_CORES-1:0]      valid = '0;
    logic                      tx, busy, overflow;
    logic [15:0]               drop_count;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int reset_events = 0;
    int framing_errors = 0;

    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    logic [7:0] exp_bytes[$];

    bit              m_last_valid;
    logic [PC_W-1:0] m_last_pc;
    logic [3:0]      m_prev_sel;

    pc_trace_uart #(
        .NUM_CORES(NUM_CORES), .PC_W(PC_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .core_sel_i(core_sel),
        .buy_ps_i(pcs), .buy_gecerli_i(valid), .tx_o(tx), .busy_o(busy),
        .overflow_o(overflow), .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(negedge rst_n) reset_events <= reset_events + 1;

    // UART receiver: samples mid-bit, discards any byte that a reset cut through.
    initial begin
        logic [7:0] b_v;
        int ev, st;
        bit ok;
        forever begin
            @(negedge tx);
            ev = reset_events;
            st = cycle;
            repeat (CLK_DIV / 2) @(posedge clk);
            #1 ok = (tx == 1'b0);
            for (int b = 0; b < 8; b++) begin
                repeat (CLK_DIV) @(posedge clk);
                #1 b_v[b] = tx;
            end
            repeat (CLK_DIV) @(posedge clk);
            #1 if (tx !== 1'b1) ok = 1'b0;
            if (ev == reset_events && rst_n) begin
                if (!ok) framing_errors++;
                rx_bytes.push_back(b_v);
                rx_start.push_back(st);
            end
        end
    end

    task automatic drive_cycle(input logic e, input logic [3:0] s, input logic [1:0] v,
                               input logic [NUM_CORES*PC_W-1:0] p, input logic c);
        en = e; core_sel = s; valid = v; pcs = p; clr = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: which cycles produce a frame and what bytes that frame carries.
    task automatic model_step(input logic e, input logic [3:0] s, input logic [1:0] v,
                              input logic [NUM_CORES*PC_W-1:0] p);
        logic [PC_W-1:0] pc;
        bit cap, dup;
        int sel;
        if (!e || s != m_prev_sel) m_last_valid = 0;
        m_prev_sel = s;
        sel = int'(s);
        cap = e && (sel < NUM_CORES) && v[sel % NUM_CORES];
        pc  = p[(sel % NUM_CORES)*PC_W +: PC_W];
`ifdef PC_TRACE_DEDUP_EN
        dup = m_last_valid && (pc == m_last_pc);
`else
        dup = 0;
`endif
        if (cap && !dup) begin
            exp_bytes.push_back({4'hA, s});
            for (int b = 0; b < NBYTES; b++) exp_bytes.push_back(pc[8*b +: 8]);
            m_last_valid = 1;
            m_last_pc = pc;
        end
    endtask

    task automatic drive_modelled(input logic e, input logic [3:0] s, input logic [1:0] v,
                                  input logic [NUM_CORES*PC_W-1:0] p);
        model_step(e, s, v, p);
        drive_cycle(e, s, v, p, 1'b0);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
        exp_bytes.delete();
        m_last_valid = 0;
        m_prev_sel = core_sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_low: got %b expected 1", tx); end
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL idle_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL idle_overflow: got %b expected 0", overflow); end
        checks++;
        if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL idle_drops: got %0d expected 0", drop_count); end
    endtask

    task automatic test_single_frame();
        logic [7:0] expv [5];
        bit ok;
        expv = '{8'hA0, 8'h80, 8'h01, 8'h01, 8'h00};
        clear_rx();
        drive_cycle(1'b1, 4'd0, 2'b01, {32'h0, 32'h0001_0180}, 1'b0);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_capture_edge: tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
        drive_cycle(1'b0, 4'd0, 2'b00, '0, 1'b0);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL single_pop_edge_tx: got %b expected 1", tx); end
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin failures++; $display("[TB] FAIL single_start_bit: got %b expected 0", tx); end
        repeat (FRAME_CYC - 3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_during_frame: got %b expected 1", busy); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after_frame: got %b expected 0", busy); end
        wait_idle(50, ok);
        checks++;
        if (rx_bytes.size() != 5) begin
            failures++; $display("[TB] FAIL single_byte_count: got %0d expected 5", rx_bytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_bytes[i] !== expv[i]) begin failures++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, rx_bytes[i], expv[i]); end
            end
            checks++;
            if (rx_start[4] - rx_start[0] != 4 * 10 * CLK_DIV) begin
                failures++; $display("[TB] FAIL single_byte_spacing: got %0d expected %0d", rx_start[4] - rx_start[0], 4 * 10 * CLK_DIV);
            end
        end
    endtask

    task automatic test_core_select();
        logic [7:0] expv [5];
        bit ok;
        expv = '{8'hA1, 8'h40, 8'h00, 8'h00, 8'h00};
        clear_rx();
        for (int c = 0; c < 6; c++)
            drive_cycle(1'b1, 4'd1, {1'(c == 3), 1'($urandom_range(0, 1))},
                        {(c == 3) ? 32'h0000_0040 : 32'($urandom), 32'($urandom)}, 1'b0);
        for (int c = 0; c < 10; c++)
            drive_cycle(1'b1, 4'd5, 2'b11, {32'($urandom), 32'($urandom)}, 1'b0);
        for (int c = 0; c < 5; c++)
            drive_cycle(1'b0, 4'd0, 2'b11, {32'($urandom), 32'($urandom)}, 1'b0);
        drive_cycle(1'b0, 4'd0, 2'b00, '0, 1'b0);
        wait_idle(3 * FRAME_CYC, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL select_drain: busy=%b expected 0 within budget", busy); end
        checks++;
        if (rx_bytes.size() != 5) begin
            failures++; $display("[TB] FAIL select_byte_count: got %0d expected 5", rx_bytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_bytes[i] !== expv[i]) begin failures++; $display("[TB] FAIL select_byte%0d: got %h expected %h", i, rx_bytes[i], expv[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [PC_W-1:0] pcv [20];
        bit ok;
        clear_rx();
        for (int i = 0; i < 20; i++) pcv[i] = 32'h0000_1000 + 32'(16 * i) + 32'($urandom_range(0, 3) << 20);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 4'd0, 2'b01, {32'h0, pcv[i]}, 1'b0);
        checks++;
        if (drop_count !== 16'd3) begin failures++; $display("[TB] FAIL overflow_drops: got %0d expected 3", drop_count); end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL overflow_flag: got %b expected 1", overflow); end
        drive_cycle(1'b1, 4'd0, 2'b01, {32'h0, 32'hDEAD_0000}, 1'b1);
        checks++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_priority: drops=%0d ovf=%b expected 0/0", drop_count, overflow);
        end
        drive_cycle(1'b1, 4'd0, 2'b01, {32'h0, 32'hDEAD_0004}, 1'b0);
        checks++;
        if (drop_count !== 16'd1 || overflow !== 1'b1) begin
            failures++; $display("[TB] FAIL drop_after_clear: drops=%0d ovf=%b expected 1/1", drop_count, overflow);
        end
        drive_cycle(1'b0, 4'd0, 2'b00, '0, 1'b1);
        drive_cycle(1'b0, 4'd0, 2'b00, '0, 1'b0);
        checks++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_pulse: drops=%0d ovf=%b expected 0/0", drop_count, overflow);
        end
        for (int i = 0; i < 17; i++) begin
            exp_bytes.push_back(8'hA0);
            for (int b = 0; b < NBYTES; b++) exp_bytes.push_back(pcv[i][8*b +: 8]);
        end
        wait_idle(18 * (FRAME_CYC + 1), ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL overflow_drain: busy=%b expected 0 within budget", busy); end
        checks++;
        if (rx_bytes.size() != exp_bytes.size()) begin
            failures++; $display("[TB] FAIL overflow_byte_count: got %0d expected %0d", rx_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                checks++;
                if (rx_bytes[i] !== exp_bytes[i]) begin failures++; $display("[TB] FAIL overflow_byte%0d: got %h expected %h", i, rx_bytes[i], exp_bytes[i]); end
            end
            checks++;
            if (rx_start[5] - rx_start[0] != FRAME_CYC + 1) begin
                failures++; $display("[TB] FAIL back_to_back_gap: got %0d expected %0d", rx_start[5] - rx_start[0], FRAME_CYC + 1);
            end
        end
    endtask

    task automatic test_dedup();
        logic [PC_W-1:0] seq [4];
        int exp_n;
        bit ok;
        seq = '{32'h100, 32'h100, 32'h100, 32'h104};
`ifdef PC_TRACE_DEDUP_EN
        exp_n = 2 * (1 + NBYTES);
`else
        exp_n = 4 * (1 + NBYTES);
`endif
        clear_rx();
        for (int i = 0; i < 4; i++) drive_modelled(1'b1, 4'd0, 2'b01, {32'h0, seq[i]});
        drive_modelled(1'b0, 4'd0, 2'b00, '0);
        wait_idle(6 * (FRAME_CYC + 1), ok);
        checks++;
        if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL dedup_drops: got %0d expected 0", drop_count); end
        checks++;
        if (rx_bytes.size() != exp_n || exp_bytes.size() != exp_n) begin
            failures++; $display("[TB] FAIL dedup_byte_count: got %0d expected %0d", rx_bytes.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (rx_bytes[i] !== exp_bytes[i]) begin failures++; $display("[TB] FAIL dedup_byte%0d: got %h expected %h", i, rx_bytes[i], exp_bytes[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_CORES*PC_W-1:0] p;
        bit ok;
        for (int r = 0; r < 4; r++) begin
            clear_rx();
            for (int c = 0; c < 12; c++) begin
                for (int k = 0; k < NUM_CORES; k++)
                    p[k*PC_W +: PC_W] = ($urandom_range(0, 1) == 1) ? 32'h200 + 32'(4 * $urandom_range(0, 1)) : 32'($urandom);
                drive_modelled(1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 3)), 2'($urandom), p);
            end
            drive_modelled(1'b0, core_sel, 2'b00, '0);
            wait_idle(14 * (FRAME_CYC + 1), ok);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL random%0d_drain: busy=%b expected 0 within budget", r, busy); end
            checks++;
            if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL random%0d_drops: got %0d expected 0", r, drop_count); end
            checks++;
            if (rx_bytes.size() != exp_bytes.size()) begin
                failures++; $display("[TB] FAIL random%0d_byte_count: got %0d expected %0d", r, rx_bytes.size(), exp_bytes.size());
            end else begin
                for (int i = 0; i < exp_bytes.size(); i++) begin
                    checks++;
                    if (rx_bytes[i] !== exp_bytes[i]) begin failures++; $display("[TB] FAIL random%0d_byte%0d: got %h expected %h", r, i, rx_bytes[i], exp_bytes[i]); end
                end
            end
        end
        checks++;
        if (framing_errors != 0) begin failures++; $display("[TB] FAIL framing: got %0d errors expected 0", framing_errors); end
    endtask

    task automatic test_reset_mid_frame();
        clear_rx();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'd0, 2'b01, {32'h0, 32'h0000_3000 + 32'(4 * i)}, 1'b0);
        drive_cycle(1'b0, 4'd0, 2'b00, '0, 1'b0);
        repeat (2 * 10 * CLK_DIV + 8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("[TB] FAIL postreset_idle: busy=%b tx=%b expected 0/1", busy, tx); end
        checks++;
        if (rx_bytes.size() != 2) begin
            failures++; $display("[TB] FAIL postreset_bytes: got %0d expected 2", rx_bytes.size());
        end else begin
            checks++;
            if (rx_bytes[0] !== 8'hA0 || rx_bytes[1] !== 8'h00) begin
                failures++; $display("[TB] FAIL prereset_bytes: got %h %h expected a0 00", rx_bytes[0], rx_bytes[1]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting pc_trace_uart bench");
        test_reset();
        test_single_frame();
        test_core_select();
        test_overflow();
        test_dedup();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_trace_uart.md
# pc_trace_uart

Parametrised instruction-trace streamer for the user project area. It watches the per-core retire interface, the program counter plus an instruction-valid strobe, of up to `NUM_CORES` cores and buffers the selected core's PCs in a FIFO. It then serialises each PC as a framed 8N1 UART packet on one `mprj_io` pin. This replaces the 32-pin parallel PC bring-out and adds buffering, multi-core selection, overflow accounting and optional stall deduplication.

## Interface
Parameters:
- `NUM_CORES`, 2: number of monitored cores; range 1..16.
- `PC_W`, 32: PC width; must be a multiple of 8.
- `FIFO_DEPTH`, 16: trace FIFO entries; must be a power of 2 and ≥2.
- `CLK_DIV`, 87: clock cycles per UART bit; must be ≥2.

Ports:
- `clk_i`  in  1  single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  capture enable. Transmission of already-buffered entries continues when low.
- `clr_i`  in  1  synchronous clear of `overflow_o` and `drop_count_o`.
- `core_sel_i`  in  4  index of the monitored core. Values ≥`NUM_CORES` select nothing.
- `buy_ps_i`  in  `NUM_CORES*PC_W`  packed PCs; core k occupies `[k*PC_W +: PC_W]`.
- `buy_gecerli_i`  in  `NUM_CORES`  per-core instruction-valid strobe.
- `tx_o`  out  1  UART TX, idle high.
- `busy_o`  out  1  high while a frame is in flight or the FIFO is non-empty.
- `overflow_o`  out  1  sticky; set when any capture is dropped.
- `drop_count_o`  out  16  count of dropped captures, saturating at 0xFFFF.

## Operation
- Capture: a capture happens in any cycle where `en_i` is high, `core_sel_i` < `NUM_CORES` and `buy_gecerli_i[core_sel_i]` is high. The FIFO entry is `{core_sel_i[3:0], PC}`, sampled in that cycle.
- Full rule: fullness is evaluated before any same-cycle pop.
  - If the FIFO is full, the capture is dropped, `overflow_o` is set and `drop_count_o` increments with saturation.
  - `clr_i` has priority over a same-cycle increment; the result is 0.
- Frame: a header byte `{4'hA, core[3:0]}` followed by `PC_W/8` PC bytes, least significant byte first.
- Each byte is sent as start(0), 8 data bits LSB first, stop(1). There is no idle gap between bytes within a frame.
- TX FSM states: IDLE → START → DATA → STOP.
  - STOP goes back to START while the byte index < `PC_W/8`, otherwise to IDLE.
  - IDLE pops the FIFO head when the FIFO is non-empty.
  - Each of START, DATA-bit and STOP holds for exactly `CLK_DIV` cycles.
- FIFO uses binary read/write pointers of width `log2(FIFO_DEPTH)+1`. Pointer wrap is handled by comparing MSBs. Full/empty are registered-pointer comparisons.
- `core_sel_i` may change at any time. It affects only subsequent captures; a frame in flight keeps its latched core id.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `overflow_o`=0, `drop_count_o`=0, FIFO empty, FSM in IDLE.
- Reset asserted mid-frame: `tx_o` returns high asynchronously and buffered entries are discarded.
- Capture to start bit:
  - The entry is written at capture edge N.
  - IDLE sees the FIFO non-empty and pops at edge N+1.
  - `tx_o` falls after edge N+2.
- Frame duration: `(1+PC_W/8)*10*CLK_DIV` cycles. With the defaults this is 5×10×87 = 4350 cycles.
- Back-to-back frames: after a STOP, the next start bit begins exactly 1 cycle later (the IDLE pop cycle).
- `busy_o` is combinational: (FSM≠IDLE) | !empty.

## Configuration
- `PC_TRACE_DEDUP_EN` defined:
  - A capture whose PC equals the last accepted PC is silently discarded. It does not count as a drop.
  - The last-PC register is invalidated on reset, on a `core_sel_i` change, and on `en_i` low.
- Undefined: every qualifying valid cycle is captured, including stall repeats.

## Test plan
- Reset then idle 100 cycles → `tx_o`=1, `busy_o`=0, `overflow_o`=0, `drop_count_o`=0.
- `CLK_DIV`=4, core 0, one valid cycle with PC 0x00010180 → bytes A0 80 01 01 00 on `tx_o`. Start bit falls 2 cycles after capture; frame lasts 200 cycles; `busy_o` then falls.
- `FIFO_DEPTH`=16, 20 consecutive valid cycles from empty/idle → 17 accepted, `drop_count_o`=3, `overflow_o`=1. Then `clr_i` pulse → both 0. All 17 frames are received in order.
- `core_sel_i`=1, core 0 strobing and core 1 valid with PC 0x00000040 → a single frame A1 40 00 00 00; core 0 activity is ignored. Setting `core_sel_i`=5 with `NUM_CORES`=2 → no captures.
- `rst_ni` pulsed low during the 3rd byte with 4 entries queued → `tx_o`=1 immediately, `busy_o`=0, and no further frames after release.
- With `PC_TRACE_DEDUP_EN`, PCs 0x100, 0x100, 0x100, 0x104 → 2 frames (0x100, 0x104), `drop_count_o`=0. Without the macro → 4 frames.
